alu_serial_sequencer: RTL and testbench
=======================================

# alu_serial_sequencer

Bit-serial control stage that drives the 1-bit `arithmetic_unit` slice over WIDTH consecutive cycles to produce a full-width arithmetic result. It sits directly upstream of the slice. It captures operands on a start request and presents one bit pair per cycle, LSB first, with the carry held in a flop. It collects the slice's sum bits and returns the result plus flags with a done pulse. This is the area-minimal path for the 32-bit ALU's arithmetic ops.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- op  in  2  slice select, same encoding as the slice: 00 → +0, 01 → +B, 10 → +~B, 11 → +1 per bit (all-ones operand)
- cin  in  1  initial carry into bit 0
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- slice_a  out  1  Ai to slice
- slice_b  out  1  Bi to slice
- slice_cin  out  1  Cini to slice
- slice_sel  out  2  sel to slice
- slice_d  in  1  Di from slice
- slice_cout  in  1  Couti from slice
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; result/flags valid
- result  out  WIDTH  sum, held until next accepted start
- cout  out  1  carry out of bit WIDTH-1
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  out  1  result == 0

## Operation
- States:
  - IDLE: start=1 captures a, b, op, and cin into shift/holding registers, clears the bit counter, and moves to RUN.
  - RUN: lasts exactly WIDTH cycles; after bit WIDTH-1 is sampled, moves to DONE.
  - DONE: lasts 1 cycle with done=1; always returns to IDLE.
- RUN, bit index i:
  - slice_a = A[i], slice_b = B[i], slice_sel = op (all combinational from registers).
  - slice_cin = cin for i=0; otherwise the carry flop, which holds slice_cout of bit i-1.
  - On the clock edge: result bit i ← slice_d, carry flop ← slice_cout, and i increments.
- Flags:
  - On the final RUN edge: cout ← slice_cout; overflow ← slice_cin XOR slice_cout.
  - zero is computed from the completed result; it is valid from DONE onward.
- Outside RUN: all slice_* outputs are driven 0.
- Operand, op, and cin changes after acceptance have no effect on the current operation.
- start in RUN or DONE is ignored; it is not queued.
- Common op/cin uses:
  - op=01, cin=0: add.
  - op=10, cin=1: subtract A−B.
  - op=00, cin=1: increment A.
  - op=11, cin=0: decrement A.
  - op=00, cin=0: pass A.
- Arithmetic is modulo 2^WIDTH.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, cout=0, overflow=0, zero=1, all slice_*=0, counter=0, carry flop=0.
- rst during RUN or DONE: aborts the operation; everything returns to reset values on the next edge, and no done is issued. rst wins over a simultaneous start.
- Latency: start sampled high in IDLE at edge T → RUN for edges T+1..T+WIDTH → done=1 during the cycle after edge T+WIDTH. This is WIDTH+1 cycles from acceptance to the done pulse.
- busy rises in the cycle after acceptance and falls together with done.
- Back-to-back: start may be asserted in the cycle done is high, but it is ignored. The earliest accepted restart is at the first IDLE cycle, giving a throughput of one op per WIDTH+2 cycles.
- The slice is purely combinational. slice_d and slice_cout are sampled at the same edge that advances the counter; there is no extra pipeline stage.
- The counter wraps only through the RUN→DONE transition; it is never free-running.

## Test plan
- Add (WIDTH=32): a=0x00000005, b=0x00000003, op=01, cin=0 → result=0x00000008, cout=0, overflow=0, zero=0; done exactly 33 cycles after the accepting edge; busy high 33 cycles.
- Subtract to zero: a=0x12345678, b=0x12345678, op=10, cin=1 → result=0, cout=1, overflow=0, zero=1.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, op=01, cin=0 → result=0x80000000, overflow=1, cout=0. Decrement wrap: a=0, op=11, cin=0 → result=0xFFFFFFFF, cout=0.
- Increment wrap: a=0xFFFFFFFF, op=00, cin=1 → result=0, cout=1, zero=1, overflow=0. Also check slice_cin equals the previous cycle's slice_cout on every RUN cycle after bit 0.
- Protocol:
  - start re-asserted with new operands mid-RUN and during DONE → ignored; original result delivered, with exactly one done per accepted start.
  - Operands changed during RUN → no effect.
- Reset mid-op: rst at RUN bit 10 → next cycle all outputs at reset values, no done pulse. A subsequent add (1+1) completes normally with result=2.

Source files
------------

// File: rtl/alu_serial_sequencer.sv
// Bit-serial arithmetic sequencer: walks a 1-bit arithmetic slice over
// WIDTH cycles, LSB first, and assembles the full-width sum and flags.
module alu_serial_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [1:0]       slice_sel,
  input  logic             slice_d,
  input  logic             slice_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic             cin_reg;
  logic [CW-1:0]    count;
  logic             carry;
  logic             last_bit;

  assign last_bit = (count == CW'(WIDTH - 1));
  assign zero     = (result == '0);

  // State register; reset always lands in IDLE, overriding any start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and slice drive; slice pins are quiet outside RUN.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    slice_a    = 1'b0;
    slice_b    = 1'b0;
    slice_cin  = 1'b0;
    slice_sel  = 2'b00;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        slice_a   = a_reg[count];
        slice_b   = b_reg[count];
        slice_sel = op_reg;
        slice_cin = (count == '0) ? cin_reg : carry;
        if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand capture, per-bit result collection, carry chain and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= 2'b00;
      cin_reg  <= 1'b0;
      count    <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            op_reg  <= op;
            cin_reg <= cin;
            count   <= '0;
            carry   <= 1'b0;
          end
        end
        RUN: begin
          result[count] <= slice_d;
          carry         <= slice_cout;
          if (last_bit) begin
            count    <= '0;
            cout     <= slice_cout;
            overflow <= slice_cin ^ slice_cout;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural 1-bit slice.
module tb_alu_serial_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic [1:0]       slice_sel;
  logic             slice_d;
  logic             slice_cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  int pass_count = 0;
  int check_count = 0;

  logic bsel;
  logic prev_cout;
  bit   prev_valid = 0;
  int   cin_err = 0;

  alu_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .a(a), .b(b),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sel(slice_sel), .slice_d(slice_d), .slice_cout(slice_cout),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero)
  );

  // Behavioural arithmetic slice: full adder with selectable B term.
  always_comb begin
    case (slice_sel)
      2'b00:   bsel = 1'b0;
      2'b01:   bsel = slice_b;
      2'b10:   bsel = ~slice_b;
      default: bsel = 1'b1;
    endcase
    slice_d    = slice_a ^ bsel ^ slice_cin;
    slice_cout = (slice_a & bsel) | (slice_a & slice_cin) | (bsel & slice_cin);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-chain monitor: slice_cin must equal previous RUN cycle's slice_cout.
  always @(negedge clk) begin
    if (!rst && busy && !done) begin
      if (prev_valid && (slice_cin !== prev_cout)) cin_err = cin_err + 1;
      prev_cout  = slice_cout;
      prev_valid = 1;
    end else begin
      prev_valid = 0;
    end
  end

  // Launch one operation and wait (bounded) for its done pulse.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [1:0] opv, input logic cv,
                       output int lat, output int busy_cycles);
    int n;
    lat = -1;
    busy_cycles = 0;
    @(negedge clk);
    a = av; b = bv; op = opv; cin = cv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (n = 1; n <= 100; n++) begin
      if (busy) busy_cycles++;
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = 2'b00; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_count++;
    if ({busy, done, cout, overflow, zero} !== 5'b00001) $display("[TB] FAIL reset_flags: got %b expected 00001", {busy, done, cout, overflow, zero});
    else pass_count++;
    check_count++;
    if (result !== '0) $display("[TB] FAIL reset_result: got %h expected 0", result);
    else pass_count++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_count++;
    if ({slice_a, slice_b, slice_cin, slice_sel} !== 5'b0) $display("[TB] FAIL idle_slice: got %b expected 00000", {slice_a, slice_b, slice_cin, slice_sel});
    else pass_count++;
  endtask

  task automatic test_add();
    int lat, bc;
    do_op(32'h5, 32'h3, 2'b01, 1'b0, lat, bc);
    check_count++;
    if (lat !== 33) $display("[TB] FAIL add_latency: got %0d expected 33", lat);
    else pass_count++;
    check_count++;
    if (bc !== 33) $display("[TB] FAIL add_busy_cycles: got %0d expected 33", bc);
    else pass_count++;
    check_count++;
    if (result !== 32'h8) $display("[TB] FAIL add_result: got %h expected 00000008", result);
    else pass_count++;
    check_count++;
    if ({cout, overflow, zero} !== 3'b000) $display("[TB] FAIL add_flags: got %b expected 000", {cout, overflow, zero});
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL add_busy_fall: got %b expected 0", busy);
    else pass_count++;
  endtask

  task automatic test_subtract_zero();
    int lat, bc;
    do_op(32'h12345678, 32'h12345678, 2'b10, 1'b1, lat, bc);
    check_count++;
    if (result !== 32'h0) $display("[TB] FAIL sub_result: got %h expected 00000000", result);
    else pass_count++;
    check_count++;
    if ({cout, overflow, zero} !== 3'b101) $display("[TB] FAIL sub_flags: got %b expected 101", {cout, overflow, zero});
    else pass_count++;
  endtask

  task automatic test_overflow();
    int lat, bc;
    do_op(32'h7FFFFFFF, 32'h1, 2'b01, 1'b0, lat, bc);
    check_count++;
    if (result !== 32'h80000000) $display("[TB] FAIL ovf_result: got %h expected 80000000", result);
    else pass_count++;
    check_count++;
    if ({cout, overflow, zero} !== 3'b010) $display("[TB] FAIL ovf_flags: got %b expected 010", {cout, overflow, zero});
    else pass_count++;
    do_op(32'h0, 32'hA5A5A5A5, 2'b11, 1'b0, lat, bc);
    check_count++;
    if (result !== 32'hFFFFFFFF) $display("[TB] FAIL dec_result: got %h expected ffffffff", result);
    else pass_count++;
    check_count++;
    if ({cout, overflow, zero} !== 3'b000) $display("[TB] FAIL dec_flags: got %b expected 000", {cout, overflow, zero});
    else pass_count++;
  endtask

  task automatic test_increment();
    int lat, bc;
    cin_err = 0;
    do_op(32'hFFFFFFFF, 32'h0, 2'b00, 1'b1, lat, bc);
    check_count++;
    if (result !== 32'h0) $display("[TB] FAIL inc_result: got %h expected 00000000", result);
    else pass_count++;
    check_count++;
    if ({cout, overflow, zero} !== 3'b101) $display("[TB] FAIL inc_flags: got %b expected 101", {cout, overflow, zero});
    else pass_count++;
    check_count++;
    if (cin_err !== 0) $display("[TB] FAIL inc_carry_chain: got %0d errors expected 0", cin_err);
    else pass_count++;
  endtask

  task automatic test_protocol();
    int done_count = 0;
    int n;
    @(negedge clk);
    a = 32'h00001000; b = 32'h00000234; op = 2'b01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (n = 1; n <= 80; n++) begin
      if (n == 10) begin
        a = 32'hDEADBEEF; b = 32'h11111111; op = 2'b10; cin = 1'b1; start = 1'b1;
      end
      if (n == 12) start = 1'b0;
      if (n == 20) begin
        a = 32'hFFFF0000; b = 32'h0000FFFF;
      end
      if (n == 32) start = 1'b1;
      if (n == 34) start = 1'b0;
      if (done) begin
        done_count++;
        check_count++;
        if (result !== 32'h00001234) $display("[TB] FAIL proto_result: got %h expected 00001234", result);
        else pass_count++;
      end
      if (n == 34) begin
        check_count++;
        if (busy !== 1'b0) $display("[TB] FAIL proto_start_in_done: got busy %b expected 0", busy);
        else pass_count++;
      end
      @(negedge clk);
    end
    check_count++;
    if (done_count !== 1) $display("[TB] FAIL proto_done_count: got %0d expected 1", done_count);
    else pass_count++;
  endtask

  task automatic test_reset_mid_op();
    int done_count = 0;
    int n, lat, bc;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h1; op = 2'b01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_count++;
    if ({busy, done, cout, overflow, zero} !== 5'b00001) $display("[TB] FAIL rst_mid_flags: got %b expected 00001", {busy, done, cout, overflow, zero});
    else pass_count++;
    check_count++;
    if (result !== '0) $display("[TB] FAIL rst_mid_result: got %h expected 0", result);
    else pass_count++;
    check_count++;
    if ({slice_a, slice_b, slice_cin, slice_sel} !== 5'b0) $display("[TB] FAIL rst_mid_slice: got %b expected 00000", {slice_a, slice_b, slice_cin, slice_sel});
    else pass_count++;
    @(negedge clk);
    rst = 1'b0;
    for (n = 0; n < 40; n++) begin
      if (done) done_count++;
      @(negedge clk);
    end
    check_count++;
    if (done_count !== 0) $display("[TB] FAIL rst_mid_no_done: got %0d expected 0", done_count);
    else pass_count++;
    do_op(32'h1, 32'h1, 2'b01, 1'b0, lat, bc);
    check_count++;
    if (result !== 32'h2) $display("[TB] FAIL rst_after_add: got %h expected 00000002", result);
    else pass_count++;
    check_count++;
    if (lat !== 33) $display("[TB] FAIL rst_after_latency: got %0d expected 33", lat);
    else pass_count++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_subtract_zero();
    test_overflow();
    test_increment();
    test_protocol();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
